// File: rtl/rsnn_neuron_array.sv
// rsnn_neuron_array: N recurrent leaky integrate-and-fire neurons.
//   clk, reset (sync, active-high, dominates enable), enable (one update per cycle)
//   external_input_current  N x W signed currents, neuron i at [i*W +: W]
//   threshold / decay / refractory_period        shared neuron parameters
//   feedback_scale / lateral_scale / feedback_mode  recurrent weights and mode
//   spike_out, membrane_out  registered per-neuron state
//   spike_total              saturating spike-event counter
module rsnn_neuron_array #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int RW = 8,
  parameter int CW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N*W-1:0]    external_input_current,
  input  logic [W-1:0]      threshold,
  input  logic [W-1:0]      decay,
  input  logic [RW-1:0]     refractory_period,
  input  logic [W-1:0]      feedback_scale,
  input  logic [W-1:0]      lateral_scale,
  input  logic [1:0]        feedback_mode,
  output logic [N-1:0]      spike_out,
  output logic [N*W-1:0]    membrane_out,
  output logic [CW-1:0]     spike_total
);

  typedef logic signed [W+1:0] wide_t;

  logic [N*W-1:0]  v_q, v_d;
  logic [N*RW-1:0] refr_q, refr_d;
  logic [N-1:0]    spike_q, spike_d;
  logic [CW-1:0]   total_q, total_d;

  function automatic wide_t sext(input logic [W-1:0] x);
    return {{2{x[W-1]}}, x};
  endfunction

  // Value fits in W bits when the top three bits of the wide sum agree.
  function automatic logic [W-1:0] sat(input wide_t x);
    if (x[W+1:W-1] == 3'b000 || x[W+1:W-1] == 3'b111)
      return x[W-1:0];
    else if (x[W+1])
      return {1'b1, {(W-1){1'b0}}};
    else
      return {1'b0, {(W-1){1'b1}}};
  endfunction

  function automatic void neuron_step(
    input  logic [W-1:0]  v,
    input  logic [RW-1:0] refr,
    input  logic [W-1:0]  ext,
    input  logic          add_fb,
    input  logic          add_lat,
    output logic [W-1:0]  v_n,
    output logic [RW-1:0] refr_n,
    output logic          spike_n
  );
    wide_t        cur;
    wide_t        lk;
    logic [W-1:0] i_sat;
    logic [W-1:0] s_w;

    cur = sext(ext)
        + (add_fb  ? sext(feedback_scale) : '0)
        + (add_lat ? sext(lateral_scale)  : '0);
    i_sat = sat(cur);

    // Leak toward zero by decay, clamping at zero instead of crossing it.
    lk = sext(v);
    if (!lk[W+1] && lk != '0) begin
      lk = lk - {2'b00, decay};
      if (lk[W+1]) lk = '0;
    end else if (lk[W+1]) begin
      lk = lk + {2'b00, decay};
      if (!lk[W+1] && lk != '0) lk = '0;
    end

    s_w = sat(lk + sext(i_sat));

    if (refr != '0) begin
      v_n     = '0;
      refr_n  = refr - 1'b1;
      spike_n = 1'b0;
    end else if ($signed(s_w) >= $signed(threshold)) begin
      v_n     = '0;
      refr_n  = refractory_period;
      spike_n = 1'b1;
    end else begin
      v_n     = s_w;
      refr_n  = '0;
      spike_n = 1'b0;
    end
  endfunction

  always_comb begin : next_state
    logic [W-1:0]  v_n;
    logic [RW-1:0] r_n;
    logic          s_n;
    logic [CW:0]   sum;

    v_d     = v_q;
    refr_d  = refr_q;
    spike_d = '0;
    v_n     = '0;
    r_n     = '0;
    s_n     = 1'b0;

    for (int unsigned i = 0; i < N; i++) begin
      neuron_step(v_q[i*W +: W], refr_q[i*RW +: RW],
                  external_input_current[i*W +: W],
                  feedback_mode[0] & spike_q[i],
                  feedback_mode[1] & spike_q[(i + N - 1) % N],
                  v_n, r_n, s_n);
      v_d[i*W +: W]     = v_n;
      refr_d[i*RW +: RW] = r_n;
      spike_d[i]        = s_n;
    end

    sum = {1'b0, total_q};
    for (int unsigned i = 0; i < N; i++)
      sum = sum + (CW+1)'(spike_d[i]);
    total_d = sum[CW] ? '1 : sum[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q     <= '0;
      refr_q  <= '0;
      spike_q <= '0;
      total_q <= '0;
    end else if (enable) begin
      v_q     <= v_d;
      refr_q  <= refr_d;
      spike_q <= spike_d;
      total_q <= total_d;
    end
  end

  assign spike_out    = spike_q;
  assign membrane_out = v_q;
  assign spike_total  = total_q;

endmodule

// File: doc/rsnn_neuron_array.md
Name: rsnn_neuron_array

Overview:
Parametrised array of N recurrent leaky integrate-and-fire neurons. Each neuron has a signed W-bit membrane and a refractory counter. Each neuron receives its own external current plus optional self-feedback, ring-lateral feedback, or both. Instantiated per layer in the RSNN tile. Successor to the single-neuron recurrent block, with channel count, data width and feedback mode generalised.

Parameters:
N, 4, number of neurons (>=2)
W, 8, data width: signed 2's-complement current, membrane, threshold and scales
RW, 8, refractory counter width
CW, 16, width of the saturating spike-event counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; dominates enable
enable  input  1  one neuron update per cycle while high; all state holds while low
external_input_current  input  N*W  signed per-neuron current; neuron i = bits [i*W +: W]
threshold  input  W  signed firing threshold, shared
decay  input  W  unsigned leak magnitude, shared
refractory_period  input  RW  refractory length in enabled updates
feedback_scale  input  W  signed self-feedback weight
lateral_scale  input  W  signed weight from neuron (i-1) mod N to neuron i
feedback_mode  input  2  00 none, 01 self, 10 ring, 11 self+ring
spike_out  output  N  registered spike flags, one bit per neuron
membrane_out  output  N*W  registered membrane potentials, same packing as inputs
spike_total  output  CW  saturating count of all spikes since reset

Behaviour:
- Reset (synchronous): all membranes = 0, refractory counters = 0, spike_out = 0, spike_total = 0. Reset mid-run discards all state on that edge regardless of enable.
- enable = 0: every register holds, including spike_out.
- Each enabled edge updates every neuron i in parallel, using spike_out from the previous update (one-update recurrence latency).
- Input current:
  - I_i = sat_W(ext_i + (mode[0] & spike_q[i] ? feedback_scale : 0) + (mode[1] & spike_q[(i-1) mod N] ? lateral_scale : 0)).
  - Sum computed at W+2 bits, sign-extended.
  - sat_W clamps to [-2^(W-1), 2^(W-1)-1].
- Refractory (refr_i != 0): refr_i decrements by 1; membrane forced to 0; spike_out[i] = 0; input ignored.
- Integrate (refr_i == 0):
  - Leak: L = V>0 ? max(V-decay, 0) : V<0 ? min(V+decay, 0) : 0. Leak never crosses zero.
  - S = sat_W(L + I_i), computed at W+2 bits.
  - Fire if S >= threshold (signed compare): spike_out[i] = 1, V = 0, refr_i = refractory_period.
  - Otherwise: spike_out[i] = 0, V = S.
- refractory_period = 0: no refractory, so a neuron can fire on consecutive updates.
- Spike pulse is one enabled update wide unless re-fired.
- spike_total: on each enabled edge, adds popcount of the new spike vector; saturates at 2^CW-1 (never wraps).
- membrane_out and spike_out are direct register outputs; no combinational path from inputs.

Test Plan:
All scenarios use N=4, W=8, RW=8, CW=16, enable held high unless stated.
- Reset: assert reset with enable=1 and ext=0x7F for 2 cycles -> spike_out=0, membrane_out=0, spike_total=0.
- Integrate/fire: ext0=20, threshold=50, decay=0, mode=00, refractory=0 -> V0 = 20, 40, then spike_out[0]=1 with V0=0 on update 3; V0=20, spike 0 on update 4; spike_total=1 after update 3.
- Leak: ext0=100 for one update then 0, decay=30, threshold=127 -> V0 = 100, 70, 40, 10, 0, 0 (no negative overshoot).
- Refractory: ext0=60, threshold=50, refractory=2 -> spikes on updates 1, 4, 7. V0=0 and spike 0 on updates 2, 3, 5, 6.
- Ring: mode=10, lateral_scale=60, threshold=50, decay=0, ext0=60 for update 1 only, others 0 -> spike_out = 0001, 0010, 0100, 1000, 0001 on successive updates. Toggle enable low mid-sequence -> pattern pauses and resumes unchanged.
- Saturation:
  - ext0=-128, threshold=0, decay=0, mode=00 -> V0 clamps at 0x80 and holds, no wrap.
  - ext0=127, feedback_scale=127, mode=01, threshold=127 -> spike every update.
  - Force spike_total to 0xFFFE via a long run -> it sticks at 0xFFFF.
